// File: rtl/y_pixel_voltage_pipe.sv
// y_pixel_voltage_pipe
//
// Converts a signed screen-space pixel row into a signed voltage reading.
// Each sample has a channel id, and each channel has its own scale exponent.
//   result = ((Y_ZERO_VOLTS - y) * VOLTAGE_RANGE <<< DEFAULT_SCALE_EXPONENT)
//            >>> DISPLAY_HEIGHT_EXPONENT >>> scaleExponent[channel]
// Every shift is arithmetic (floor rounding). The full internal precision is
// kept until the final limit stage.
//
// The pipeline has four stages:
//   1. subtract / multiply
//   2. scale-up / height shift
//   3. per-channel shift
//   4. limit / absolute value
// Data leaves the pipeline 4 cycles after the input transfer.
// Every stage holds while the output is stalled (outValid && !outReady).
//
// Build option:
//   Y_PIXEL_VOLTAGE_SATURATE_EN  defined: an out-of-range result clamps
//                                symmetrically to +/-(2^(VOLTAGE_BITS-1)-1).
//                                undefined: the result wraps to the low
//                                VOLTAGE_BITS bits.
//
// Ports:
//   clock, reset                      rising-edge clock, sync active-high reset
//   inValid / inReady                 input handshake
//   y, inChannel                      signed pixel row and channel of the sample
//   cfgWrite, cfgChannel,
//   cfgScaleExponent                  per-channel scale exponent write port
//   outValid / outReady               output handshake
//   voltage, voltageAbsoluteValue,
//   isNegative, outChannel            result and its channel
module y_pixel_voltage_pipe #(
  parameter int VOLTAGE_BITS            = 12,
  parameter int DISPLAY_Y_BITS          = 12,
  parameter int SCALE_EXPONENT_BITS     = 4,
  parameter int NUM_CHANNELS            = 4,
  parameter int CHANNEL_BITS            = 2,
  parameter int Y_ZERO_VOLTS            = 384,
  parameter int VOLTAGE_RANGE           = 256,
  parameter int DEFAULT_SCALE_EXPONENT  = 3,
  parameter int DISPLAY_HEIGHT_EXPONENT = 10
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             inValid,
  output logic                             inReady,
  input  logic signed [DISPLAY_Y_BITS-1:0] y,
  input  logic [CHANNEL_BITS-1:0]          inChannel,
  input  logic                             cfgWrite,
  input  logic [CHANNEL_BITS-1:0]          cfgChannel,
  input  logic [SCALE_EXPONENT_BITS-1:0]   cfgScaleExponent,
  output logic                             outValid,
  input  logic                             outReady,
  output logic signed [VOLTAGE_BITS-1:0]   voltage,
  output logic [VOLTAGE_BITS-1:0]          voltageAbsoluteValue,
  output logic                             isNegative,
  output logic [CHANNEL_BITS-1:0]          outChannel
);

  // Internal widths are sized so that no intermediate result overflows.
  localparam int R_W      = DISPLAY_Y_BITS + 1;
  localparam int VR_W     = $clog2(VOLTAGE_RANGE + 1) + 1;
  localparam int PROD_W   = R_W + VR_W;
  localparam int SCALED_W = PROD_W + DEFAULT_SCALE_EXPONENT;

  localparam logic signed [R_W-1:0]    Y_ZERO_S = R_W'(Y_ZERO_VOLTS);
  localparam logic signed [PROD_W-1:0] VR_S     = PROD_W'(VOLTAGE_RANGE);

  // Per-channel scale exponents.
  logic [SCALE_EXPONENT_BITS-1:0] scale_exp_reg [NUM_CHANNELS];

  // Pipeline registers.
  logic                           s1_valid_reg;
  logic signed [PROD_W-1:0]       s1_prod_reg;
  logic [SCALE_EXPONENT_BITS-1:0] s1_exp_reg;
  logic [CHANNEL_BITS-1:0]        s1_chan_reg;

  logic                           s2_valid_reg;
  logic signed [SCALED_W-1:0]     s2_val_reg;
  logic [SCALE_EXPONENT_BITS-1:0] s2_exp_reg;
  logic [CHANNEL_BITS-1:0]        s2_chan_reg;

  logic                           s3_valid_reg;
  logic signed [SCALED_W-1:0]     s3_val_reg;
  logic [CHANNEL_BITS-1:0]        s3_chan_reg;

  logic                           out_valid_reg;
  logic signed [VOLTAGE_BITS-1:0] voltage_reg;
  logic [VOLTAGE_BITS-1:0]        abs_reg;
  logic                           neg_reg;
  logic [CHANNEL_BITS-1:0]        out_chan_reg;

  // Combinational next values.
  logic                           advance;
  logic signed [R_W-1:0]          r_next;
  logic signed [PROD_W-1:0]       prod_next;
  logic [SCALE_EXPONENT_BITS-1:0] exp_next;
  logic signed [SCALED_W-1:0]     scaled_up;
  logic signed [SCALED_W-1:0]     s2_val_next;
  logic signed [SCALED_W-1:0]     s3_val_next;
  logic signed [VOLTAGE_BITS-1:0] volt_next;
  logic [VOLTAGE_BITS-1:0]        abs_next;
  logic                           neg_next;

  // The pipeline is stalled only while a valid result sits unaccepted at
  // the output. A bubble at the output never blocks the stages behind it.
  assign advance = !(out_valid_reg && !outReady);
  assign inReady = advance;

  // Stage 1: r = Y_ZERO - y (screen Y grows downward), then multiply by the
  // voltage span. The channel exponent is captured at acceptance, so a
  // cfgWrite in the same cycle only affects later samples.
  always_comb begin
    r_next    = Y_ZERO_S - R_W'(y);
    prod_next = PROD_W'(r_next) * VR_S;
    exp_next  = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (inChannel == CHANNEL_BITS'(i)) begin
        exp_next = scale_exp_reg[i];
      end
    end
  end

  // Stage 2: default scale-up, then divide by the display height.
  always_comb begin
    scaled_up   = SCALED_W'(s1_prod_reg);
    s2_val_next = (scaled_up <<< DEFAULT_SCALE_EXPONENT) >>> DISPLAY_HEIGHT_EXPONENT;
  end

  // Stage 3: per-channel shift. A large exponent drains the value to 0 or -1.
  assign s3_val_next = s2_val_reg >>> s2_exp_reg;

  // Stage 4: limit to the output width, then derive sign and magnitude.
`ifdef Y_PIXEL_VOLTAGE_SATURATE_EN
  localparam logic signed [SCALED_W-1:0] SAT_POS = SCALED_W'((2 ** (VOLTAGE_BITS - 1)) - 1);
  localparam logic signed [SCALED_W-1:0] SAT_NEG = -SAT_POS;
  logic signed [SCALED_W-1:0] clamped;

  always_comb begin
    clamped = s3_val_reg;
    if (s3_val_reg > SAT_POS) begin
      clamped = SAT_POS;
    end else if (s3_val_reg < SAT_NEG) begin
      clamped = SAT_NEG;
    end
    volt_next = VOLTAGE_BITS'(clamped);
  end
`else
  // Two's-complement wrap. The magnitude of the most negative code is
  // still representable as an unsigned value.
  assign volt_next = VOLTAGE_BITS'(s3_val_reg);
`endif

  always_comb begin
    neg_next = volt_next[VOLTAGE_BITS-1];
    abs_next = neg_next ? VOLTAGE_BITS'(-volt_next) : VOLTAGE_BITS'(volt_next);
  end

  // Scale exponent registers. Writes are accepted in every cycle, stalled or
  // not. A channel id with no matching register is ignored.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (reset) begin
        scale_exp_reg[i] <= '0;
      end else if (cfgWrite && (cfgChannel == CHANNEL_BITS'(i))) begin
        scale_exp_reg[i] <= cfgScaleExponent;
      end
    end
  end

  // Pipeline advance.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_reg  <= 1'b0;
      s1_prod_reg   <= '0;
      s1_exp_reg    <= '0;
      s1_chan_reg   <= '0;
      s2_valid_reg  <= 1'b0;
      s2_val_reg    <= '0;
      s2_exp_reg    <= '0;
      s2_chan_reg   <= '0;
      s3_valid_reg  <= 1'b0;
      s3_val_reg    <= '0;
      s3_chan_reg   <= '0;
      out_valid_reg <= 1'b0;
      voltage_reg   <= '0;
      abs_reg       <= '0;
      neg_reg       <= 1'b0;
      out_chan_reg  <= '0;
    end else if (advance) begin
      s1_valid_reg  <= inValid;
      s1_prod_reg   <= prod_next;
      s1_exp_reg    <= exp_next;
      s1_chan_reg   <= inChannel;
      s2_valid_reg  <= s1_valid_reg;
      s2_val_reg    <= s2_val_next;
      s2_exp_reg    <= s1_exp_reg;
      s2_chan_reg   <= s1_chan_reg;
      s3_valid_reg  <= s2_valid_reg;
      s3_val_reg    <= s3_val_next;
      s3_chan_reg   <= s2_chan_reg;
      out_valid_reg <= s3_valid_reg;
      voltage_reg   <= volt_next;
      abs_reg       <= abs_next;
      neg_reg       <= neg_next;
      out_chan_reg  <= s3_chan_reg;
    end
  end

  assign outValid             = out_valid_reg;
  assign voltage              = voltage_reg;
  assign voltageAbsoluteValue = abs_reg;
  assign isNegative           = neg_reg;
  assign outChannel           = out_chan_reg;

endmodule

// File: tb/tb_y_pixel_voltage_pipe.sv
// Testbench for y_pixel_voltage_pipe.
// Stimulus pushes expected results into a scoreboard queue. A separate
// monitor pops an entry and compares it on every output transfer.
// Expected values come from spec constants (directed cases) or from an
// arithmetic reference model (random cases).
module tb_y_pixel_voltage_pipe;

  localparam int VB  = 12;
  localparam int YB  = 12;
  localparam int EB  = 4;
  localparam int NCH = 4;
  localparam int CB  = 2;
  localparam int Y0  = 384;
  localparam int VR  = 256;
  localparam int DSE = 3;
  localparam int DHE = 10;

`ifdef Y_PIXEL_VOLTAGE_SATURATE_EN
  localparam longint Y_MIN_EXPECT = 2047;
`else
  localparam longint Y_MIN_EXPECT = 768;
`endif

  logic                  clock;
  logic                  reset;
  logic                  inValid;
  logic                  inReady;
  logic signed [YB-1:0]  y;
  logic [CB-1:0]         inChannel;
  logic                  cfgWrite;
  logic [CB-1:0]         cfgChannel;
  logic [EB-1:0]         cfgScaleExponent;
  logic                  outValid;
  logic                  outReady;
  logic signed [VB-1:0]  voltage;
  logic [VB-1:0]         voltageAbsoluteValue;
  logic                  isNegative;
  logic [CB-1:0]         outChannel;

  y_pixel_voltage_pipe #(
    .VOLTAGE_BITS(VB), .DISPLAY_Y_BITS(YB), .SCALE_EXPONENT_BITS(EB),
    .NUM_CHANNELS(NCH), .CHANNEL_BITS(CB), .Y_ZERO_VOLTS(Y0),
    .VOLTAGE_RANGE(VR), .DEFAULT_SCALE_EXPONENT(DSE),
    .DISPLAY_HEIGHT_EXPONENT(DHE)
  ) dut (
    .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady),
    .y(y), .inChannel(inChannel), .cfgWrite(cfgWrite),
    .cfgChannel(cfgChannel), .cfgScaleExponent(cfgScaleExponent),
    .outValid(outValid), .outReady(outReady), .voltage(voltage),
    .voltageAbsoluteValue(voltageAbsoluteValue), .isNegative(isNegative),
    .outChannel(outChannel)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  longint cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    longint v;
    int     ch;
    bit     lat;
    longint issue;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   tb_exp [NCH];

  task automatic check(input string nm, input longint act, input longint expv);
    n_vec++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic longint pow2(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 2;
    return p;
  endfunction

  // Floor division for a positive divisor.
  function automatic longint fdiv(input longint a, input longint b);
    longint q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Reference model: real-valued formula, floor rounding, then limiting.
  function automatic longint model(input int yv, input int e);
    longint r = longint'(Y0) - longint'(yv);
    longint q = fdiv(fdiv(r * VR * pow2(DSE), pow2(DHE)), pow2(e));
`ifdef Y_PIXEL_VOLTAGE_SATURATE_EN
    longint lim = pow2(VB - 1) - 1;
    if (q > lim) q = lim;
    if (q < -lim) q = -lim;
`else
    longint m = pow2(VB);
    q = ((q % m) + m) % m;
    if (q >= m / 2) q = q - m;
`endif
    return q;
  endfunction

  // One stimulus cycle. Inputs are driven on the falling edge.
  // An accepted sample gets its expected response queued.
  task automatic step(input bit v, input int yv, input int ch, input bit cw,
                      input int cc, input int ce, input bit ordy, input bit lat,
                      input bit use_c, input longint cval, output bit acc);
    exp_t e;
    @(negedge clock);
    inValid          = v;
    y                = yv[YB-1:0];
    inChannel        = ch[CB-1:0];
    cfgWrite         = cw;
    cfgChannel       = cc[CB-1:0];
    cfgScaleExponent = ce[EB-1:0];
    outReady         = ordy;
    #1;
    acc = v && inReady && !reset;
    if (acc) begin
      e.v     = use_c ? cval : model(yv, tb_exp[ch]);
      e.ch    = ch;
      e.lat   = lat;
      e.issue = cyc;
      sb.push_back(e);
    end
    if (cw && cc < NCH) tb_exp[cc] = ce;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, acc);
  endtask

  task automatic cfg(input int cc, input int ce);
    bit acc;
    step(0, 0, 0, 1, cc, ce, 1, 0, 0, 0, acc);
  endtask

  task automatic send_c(input int yv, input int ch, input longint cval, input bit lat);
    bit acc = 0;
    for (int k = 0; k < 50 && !acc; k++) step(1, yv, ch, 0, 0, 0, 1, lat, 1, cval, acc);
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, k[0]);
    check("drain", sb.size(), 0);
  endtask

  // Monitor: compares every output transfer against the scoreboard and
  // checks stall behaviour.
  initial begin : monitor
    exp_t   e;
    bit     prev_stall = 0;
    longint prev_v = 0;
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        prev_stall = 0;
      end else begin
        if (prev_stall && outValid) check("stall_hold", longint'(voltage), prev_v);
        if (outValid && !outReady) begin
          check("stall_inready", longint'(inReady), 0);
          prev_stall = 1;
          prev_v     = longint'(voltage);
        end else begin
          prev_stall = 0;
        end
        if (outValid && outReady) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_output: got voltage %0d, required no output", voltage);
          end else begin
            e = sb.pop_front();
            check("voltage", longint'(voltage), e.v);
            check("abs", longint'(voltageAbsoluteValue), (e.v < 0) ? -e.v : e.v);
            check("isNegative", longint'(isNegative), (e.v < 0) ? 1 : 0);
            check("outChannel", longint'(outChannel), e.ch);
            if (e.lat) check("latency", cyc - e.issue, 4);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit acc;
    int ys [8];
    int idx;
    for (int i = 0; i < NCH; i++) tb_exp[i] = 0;
    reset = 1; inValid = 0; y = '0; inChannel = '0; cfgWrite = 0;
    cfgChannel = '0; cfgScaleExponent = '0; outReady = 0;

    // Reset state.
    repeat (3) @(negedge clock);
    #1;
    check("reset_outValid", outValid, 0);
    check("reset_voltage", voltage, 0);
    check("reset_abs", voltageAbsoluteValue, 0);
    check("reset_isNegative", isNegative, 0);
    check("reset_outChannel", outChannel, 0);
    reset = 0;
    @(negedge clock);
    #1;
    check("inReady_after_reset", inReady, 1);

    // Directed cases.
    cfg(1, 3);
    send_c(0, 0, 768, 1);
    send_c(0, 1, 96, 0);
    send_c(767, 0, -766, 0);
    step(1, 385, 2, 1, 2, 2, 1, 0, 1, -2, acc);  // same-cycle cfg uses the old exponent
    send_c(385, 2, -1, 0);
    cfg(3, 15);
    send_c(383, 3, 0, 0);
    send_c(-2048, 0, Y_MIN_EXPECT, 0);
    idle(8);
    wait_drain();

    // Back-to-back stream of 8 samples with a 3-cycle output stall.
    for (int i = 0; i < 8; i++) ys[i] = int'($urandom_range(0, 4095)) - 2048;
    idx = 0;
    for (int t = 0; t < 60 && idx < 8; t++) begin
      step(1, ys[idx], idx % NCH, 0, 0, 0, !(t >= 5 && t < 8), 0, 0, 0, acc);
      if (acc) idx++;
    end
    check("stream_all_accepted", idx, 8);
    wait_drain();

    // Reset with three samples in flight.
    cfg(1, 5);
    for (int i = 0; i < 3; i++) step(1, 100 * i, 1, 0, 0, 0, 1, 0, 0, 0, acc);
    @(negedge clock);
    inValid = 0;
    reset   = 1;
    @(negedge clock);
    sb.delete();
    for (int i = 0; i < NCH; i++) tb_exp[i] = 0;
    #1;
    check("reset_flush_outValid", outValid, 0);
    reset = 0;
    idle(6);
    send_c(0, 1, 768, 0);
    send_c(0, 3, 768, 0);
    idle(6);
    wait_drain();

    // Random traffic with random backpressure and config writes.
    for (int t = 0; t < 500; t++) begin
      step(($urandom % 4) != 0, int'($urandom_range(0, 4095)) - 2048,
           int'($urandom_range(0, NCH - 1)), ($urandom % 5) == 0,
           int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 15)),
           ($urandom % 4) != 0, 0, 0, 0, acc);
    end
    idle(6);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
